// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the L1 instruction
// cache and the L1 data cache. One requester owns memory at a time, the grant
// is held until memory responds, and simultaneous requests alternate
// round-robin so neither cache can starve the other.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // last_grant_d is high when the data cache won the most recent grant; the
  // opposite side wins the next tie.
  logic                  last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Arbitration decision, only meaningful while idle; ties go to the side
  // that was not served last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        if (last_grant_d) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Next-state logic and command/response steering; the granted side's
  // captured command is driven until memory answers.
  always_comb begin
    next_state  = state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i) begin
          next_state = GRANT_I;
        end else if (grant_d) begin
          next_state = GRANT_D;
        end
      end
      GRANT_I: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          next_state  = RELEASE;
        end
      end
      GRANT_D: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          next_state  = RELEASE;
        end
      end
      RELEASE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the winner's command when a grant is issued, so later changes on
  // the requester inputs cannot disturb a transaction memory has started.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      last_grant_d <= 1'b0;
    end else if (grant_i) begin
      addr_q       <= i_pmem_address;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      addr_q       <= d_pmem_address;
      wdata_q      <= d_pmem_wdata;
      write_q      <= d_pmem_write;
      last_grant_d <= 1'b1;
    end
  end

  // Captured address and data go straight to memory; read data is shared by
  // both caches because only the resp pulses identify the owner.
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model of
// who owns memory.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: owner 0 = memory free, 1 = icache, 2 = dcache; gap marks
  // the dead cycle after a response; last_d records who won most recently.
  int            owner = 0;
  bit            gap = 1'b0;
  bit            last_d = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [LW-1:0] cap_wdata = '0;
  bit            cap_write = 1'b0;
  bit            model_iresp = 1'b0;
  bit            model_dresp = 1'b0;

  // Observation bookkeeping used by the directed scenarios.
  int cycle_no = 0;
  bit prev_cmd = 1'b0;
  int cmd_age = 0;
  int read_cnt = 0;
  int write_cnt = 0;
  int iresp_cnt = 0;
  int dresp_cnt = 0;
  int cmd_start_q[$];
  int resp_cyc_q[$];
  int resp_who_q[$];

  // Compare one observed value with the expected one and count it.
  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle_no);
    end
  endtask

  task automatic clearObservations();
    read_cnt  = 0;
    write_cnt = 0;
    iresp_cnt = 0;
    dresp_cnt = 0;
    cmd_start_q.delete();
    resp_cyc_q.delete();
    resp_who_q.delete();
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input bit rn, input bit ir, input logic [AW-1:0] ia,
                               input bit dr, input bit dw, input logic [AW-1:0] da,
                               input logic [LW-1:0] dwd, input bit pr,
                               input logic [LW-1:0] prd);
    bit cur_cmd;
    int win;
    @(negedge clk);
    rst_n          = rn;
    i_pmem_read    = ir;
    i_pmem_address = ia;
    d_pmem_read    = dr;
    d_pmem_write   = dw;
    d_pmem_address = da;
    d_pmem_wdata   = dwd;
    pmem_resp      = pr;
    pmem_rdata     = prd;
    #1;
    model_iresp = (owner == 1) && pr;
    model_dresp = (owner == 2) && pr;
    checkOutput("pmem_read", pmem_read, (owner != 0) && !cap_write);
    checkOutput("pmem_write", pmem_write, (owner != 0) && cap_write);
    checkOutput("pmem_address", pmem_address, cap_addr);
    checkOutput("pmem_wdata", pmem_wdata, cap_wdata);
    checkOutput("i_pmem_resp", i_pmem_resp, model_iresp);
    checkOutput("d_pmem_resp", d_pmem_resp, model_dresp);
    checkOutput("i_pmem_rdata", i_pmem_rdata, prd);
    checkOutput("d_pmem_rdata", d_pmem_rdata, prd);

    cur_cmd = pmem_read | pmem_write;
    if (cur_cmd && !prev_cmd) cmd_start_q.push_back(cycle_no);
    prev_cmd = cur_cmd;
    cmd_age  = cur_cmd ? cmd_age + 1 : 0;
    if (pmem_read) read_cnt++;
    if (pmem_write) write_cnt++;
    if (i_pmem_resp) begin
      iresp_cnt++;
      resp_cyc_q.push_back(cycle_no);
      resp_who_q.push_back(1);
    end
    if (d_pmem_resp) begin
      dresp_cnt++;
      resp_cyc_q.push_back(cycle_no);
      resp_who_q.push_back(2);
    end

    @(posedge clk);
    if (!rn) begin
      owner     = 0;
      gap       = 1'b0;
      last_d    = 1'b0;
      cap_addr  = '0;
      cap_wdata = '0;
      cap_write = 1'b0;
    end else if (owner != 0) begin
      if (pr) begin
        owner = 0;
        gap   = 1'b1;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else begin
      win = 0;
      if (ir && (dr || dw)) win = last_d ? 1 : 2;
      else if (ir) win = 1;
      else if (dr || dw) win = 2;
      if (win == 1) begin
        owner     = 1;
        last_d    = 1'b0;
        cap_addr  = ia;
        cap_wdata = '0;
        cap_write = 1'b0;
      end else if (win == 2) begin
        owner     = 2;
        last_d    = 1'b1;
        cap_addr  = da;
        cap_wdata = dwd;
        cap_write = dw;
      end
    end
    cycle_no++;
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    logic [LW-1:0] a5;
    logic [LW-1:0] wb;
    logic [LW-1:0] rnd;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    bit            i_busy;
    bit            d_busy;
    bit            dr;
    bit            dw;
    bit            pr;
    bit            rn;
    logic [LW-1:0] dwd;

    a5 = {16{8'hA5}};
    wb = 128'h0123456789ABCDEF0123456789ABCDEF;

    // Reset state.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] single icache read");
    clearObservations();
    applyStimulus(1, 1, 16'h1230, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h1230, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h1230, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h1230, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h1230, 0, 0, 0, 0, 1, a5);
    applyStimulus(1, 0, 16'h1230, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s1_read_cycles", read_cnt, 4);
    checkOutput("s1_iresp_pulses", iresp_cnt, 1);
    checkOutput("s1_dresp_pulses", dresp_cnt, 0);
    if (cmd_start_q.size() > 0) checkOutput("s1_cmd_start", cmd_start_q[0], cycle_no - 6);

    $display("[TB] round-robin ties after reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearObservations();
    cmd_age = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1, 1, 16'h1110, 1, 0, 16'h2220, 0, cmd_age >= 1,
                    {$urandom, $urandom, $urandom, $urandom});
    end
    checkOutput("s2_resp_count", resp_who_q.size() >= 3, 1);
    if (resp_who_q.size() >= 3) begin
      checkOutput("s2_first_owner", resp_who_q[0], 2);
      checkOutput("s2_second_owner", resp_who_q[1], 1);
      checkOutput("s2_third_owner", resp_who_q[2], 2);
    end
    if (cmd_start_q.size() >= 2 && resp_cyc_q.size() >= 1)
      checkOutput("s2_regrant_gap", cmd_start_q[1] - resp_cyc_q[0], 3);

    $display("[TB] dcache writeback with address change");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearObservations();
    applyStimulus(1, 0, 0, 0, 1, 16'h4440, wb, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h9990, wb, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h9990, ~wb, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h9990, ~wb, 1, 0);
    checkOutput("s3_write_cycles", write_cnt, 3);
    checkOutput("s3_read_cycles", read_cnt, 0);
    checkOutput("s3_dresp_pulses", dresp_cnt, 1);

    $display("[TB] spurious responses in RELEASE and IDLE");
    clearObservations();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, a5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, a5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, a5);
    checkOutput("s5_no_resp", iresp_cnt + dresp_cnt, 0);

    $display("[TB] dcache read and write together");
    clearObservations();
    applyStimulus(1, 0, 0, 1, 1, 16'h5550, wb, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 16'h5550, wb, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 16'h5550, wb, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s4_write_cycles", write_cnt, 2);
    checkOutput("s4_read_cycles", read_cnt, 0);

    $display("[TB] reset during icache grant");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h2220, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h2220, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'h2220, 0, 0, 0, 0, 0, 0);
    clearObservations();
    cmd_age = 0;
    applyStimulus(1, 1, 16'h2220, 1, 0, 16'h3330, 0, 1, a5);
    checkOutput("s6_no_cmd_after_reset", read_cnt + write_cnt, 0);
    checkOutput("s6_no_iresp", iresp_cnt, 0);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1, 1, 16'h2220, 1, 0, 16'h3330, 0, cmd_age >= 1, a5);
    end
    checkOutput("s6_has_resp", resp_who_q.size() >= 1, 1);
    if (resp_who_q.size() >= 1) checkOutput("s6_tie_owner", resp_who_q[0], 2);

    $display("[TB] randomized traffic");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_busy = 1'b0;
    d_busy = 1'b0;
    ia = '0;
    da = '0;
    dr = 1'b0;
    dw = 1'b0;
    dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_busy && $urandom_range(3) == 0) begin
        i_busy = 1'b1;
        ia = 16'($urandom);
      end
      if (!d_busy && $urandom_range(3) == 0) begin
        d_busy = 1'b1;
        da = 16'($urandom);
        case ($urandom_range(7))
          0:       {dr, dw} = 2'b11;
          1, 2, 3: {dr, dw} = 2'b01;
          default: {dr, dw} = 2'b10;
        endcase
        dwd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (d_busy && $urandom_range(15) == 0) da = 16'($urandom);
      if (i_busy && $urandom_range(31) == 0) i_busy = 1'b0;
      if (d_busy && $urandom_range(31) == 0) d_busy = 1'b0;
      pr  = ($urandom_range(3) == 0);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rn  = ($urandom_range(149) != 0);
      applyStimulus(rn, i_busy, ia, d_busy & dr, d_busy & dw, da, dwd, pr, rnd);
      if (model_iresp) i_busy = 1'b0;
      if (model_dresp) d_busy = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
